id_ex_pipeline_reg: RTL and testbench

//   ID/EX pipeline register: the consumer of the load-use stall request and the producer of
//   the ID_EX_MemRead/ID_EX_RtAddr signals that the hazard detection logic compares against.
//   It captures decoded control and operand data from ID each cycle. It inserts a bubble
//   (all control zeroed) on a hazard stall, clears on a branch flush, and freezes on a global

---
 rtl/id_ex_pipeline_reg_pkg.sv | 68 ++++++
 rtl/id_ex_pipeline_reg_sat_counter.sv | 20 ++
 rtl/id_ex_pipeline_reg.sv | 111 +++++++++++
 tb/tb_id_ex_pipeline_reg.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pipeline_reg_pkg.sv
// Shared pipeline-register definitions: control bundle, bubble encoding and the
// hold/bubble/capture selection reused by every stage register.
package id_ex_pipeline_reg_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ADDR_W_DEF  = 5;
  localparam int unsigned ALUOP_W_DEF = 2;
  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned CTRL_W      = 6 + ALUOP_W_DEF;

  typedef struct packed {
    logic                   regWrite;
    logic                   memtoReg;
    logic                   memRead;
    logic                   memWrite;
    logic                   aluSrc;
    logic                   regDst;
    logic [ALUOP_W_DEF-1:0] aluOp;
  } ctrl_t;

  // A bubble has every control bit low, so it can never write state or start a load.
  localparam ctrl_t BUBBLE_CTRL = '0;

  typedef enum logic [1:0] {
    LOAD_HOLD,
    LOAD_BUBBLE,
    LOAD_CAPTURE
  } load_e;

  // A global freeze outranks everything; stall and flush both collapse to one bubble.
  function automatic load_e pipeLoadSel(input logic memStall,
                                        input logic stall,
                                        input logic flush);
    load_e sel;
    if (memStall)
      sel = LOAD_HOLD;
    else if (stall || flush)
      sel = LOAD_BUBBLE;
    else
      sel = LOAD_CAPTURE;
    return sel;
  endfunction

  function automatic ctrl_t pipeCtrlNext(input load_e sel,
                                         input ctrl_t cur,
                                         input ctrl_t nxt);
    ctrl_t res;
    unique case (sel)
      LOAD_HOLD:    res = cur;
      LOAD_BUBBLE:  res = BUBBLE_CTRL;
      LOAD_CAPTURE: res = nxt;
      default:      res = BUBBLE_CTRL;
    endcase
    return res;
  endfunction

  function automatic logic pipeValidNext(input load_e sel, input logic cur);
    logic res;
    unique case (sel)
      LOAD_HOLD:    res = cur;
      LOAD_BUBBLE:  res = 1'b0;
      LOAD_CAPTURE: res = 1'b1;
      default:      res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/id_ex_pipeline_reg_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset; sticks at all-ones.
module sat_counter
  import id_ex_pipeline_reg_pkg::*;
#(
  parameter int unsigned W = CNT_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt_o <= '0;
    else if (inc_i && (cnt_o != '1))
      cnt_o <= cnt_o + W'(1);
  end

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: captures decoded control and operands, inserts bubbles on
// hazard stall or flush, freezes on memory stall, and counts inserted bubbles.
module id_ex_pipeline_reg
  import id_ex_pipeline_reg_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned ALUOP_W = ALUOP_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               mem_stall_i,
  input  logic               RegWrite_i,
  input  logic               MemtoReg_i,
  input  logic               MemRead_i,
  input  logic               MemWrite_i,
  input  logic               ALUSrc_i,
  input  logic               RegDst_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic [DATA_W-1:0]  RsData_i,
  input  logic [DATA_W-1:0]  RtData_i,
  input  logic [DATA_W-1:0]  Imm_i,
  input  logic [ADDR_W-1:0]  RsAddr_i,
  input  logic [ADDR_W-1:0]  RtAddr_i,
  input  logic [ADDR_W-1:0]  RdAddr_i,
  output logic               RegWrite_o,
  output logic               MemtoReg_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic               ALUSrc_o,
  output logic               RegDst_o,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic [DATA_W-1:0]  RsData_o,
  output logic [DATA_W-1:0]  RtData_o,
  output logic [DATA_W-1:0]  Imm_o,
  output logic [ADDR_W-1:0]  RsAddr_o,
  output logic [ADDR_W-1:0]  RtAddr_o,
  output logic [ADDR_W-1:0]  RdAddr_o,
  output logic               valid_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  load_e loadSel;
  ctrl_t ctrlIn;
  ctrl_t ctrlQ;
  logic  validQ;

  always_comb begin
    ctrlIn          = BUBBLE_CTRL;
    ctrlIn.regWrite = RegWrite_i;
    ctrlIn.memtoReg = MemtoReg_i;
    ctrlIn.memRead  = MemRead_i;
    ctrlIn.memWrite = MemWrite_i;
    ctrlIn.aluSrc   = ALUSrc_i;
    ctrlIn.regDst   = RegDst_i;
    ctrlIn.aluOp    = ALUOp_i;
  end

  assign loadSel = pipeLoadSel(mem_stall_i, stall_i, flush_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrlQ  <= BUBBLE_CTRL;
      validQ <= 1'b0;
    end else begin
      ctrlQ  <= pipeCtrlNext(loadSel, ctrlQ, ctrlIn);
      validQ <= pipeValidNext(loadSel, validQ);
    end
  end

  // Operands follow the inputs on bubbles too, keeping forwarding compares deterministic.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      RsData_o <= '0;
      RtData_o <= '0;
      Imm_o    <= '0;
      RsAddr_o <= '0;
      RtAddr_o <= '0;
      RdAddr_o <= '0;
    end else if (loadSel != LOAD_HOLD) begin
      RsData_o <= RsData_i;
      RtData_o <= RtData_i;
      Imm_o    <= Imm_i;
      RsAddr_o <= RsAddr_i;
      RtAddr_o <= RtAddr_i;
      RdAddr_o <= RdAddr_i;
    end
  end

  assign RegWrite_o = ctrlQ.regWrite;
  assign MemtoReg_o = ctrlQ.memtoReg;
  assign MemRead_o  = ctrlQ.memRead;
  assign MemWrite_o = ctrlQ.memWrite;
  assign ALUSrc_o   = ctrlQ.aluSrc;
  assign RegDst_o   = ctrlQ.regDst;
  assign ALUOp_o    = ctrlQ.aluOp;
  assign valid_o    = validQ;

  sat_counter #(
    .W(CNT_W)
  ) u_bubbleCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (loadSel == LOAD_BUBBLE),
    .cnt_o (bubble_cnt_o)
  );

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Directed + randomized bench for id_ex_pipeline_reg against a behavioural reference model.
module tb_id_ex_pipeline_reg;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int OW = 2;
  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          stall_i, flush_i, mem_stall_i;
  logic          RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i;
  logic [OW-1:0] ALUOp_i;
  logic [DW-1:0] RsData_i, RtData_i, Imm_i;
  logic [AW-1:0] RsAddr_i, RtAddr_i, RdAddr_i;
  logic          RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o;
  logic [OW-1:0] ALUOp_o;
  logic [DW-1:0] RsData_o, RtData_o, Imm_o;
  logic [AW-1:0] RsAddr_o, RtAddr_o, RdAddr_o;
  logic          valid_o;
  logic [CW-1:0] bubble_cnt_o;

  id_ex_pipeline_reg #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .ALUOP_W(OW),
    .CNT_W  (CW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .mem_stall_i(mem_stall_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i), .ALUOp_i(ALUOp_i),
    .RsData_i(RsData_i), .RtData_i(RtData_i), .Imm_i(Imm_i),
    .RsAddr_i(RsAddr_i), .RtAddr_i(RtAddr_i), .RdAddr_i(RdAddr_i),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o), .RegDst_o(RegDst_o), .ALUOp_o(ALUOp_o),
    .RsData_o(RsData_o), .RtData_o(RtData_o), .Imm_o(Imm_o),
    .RsAddr_o(RsAddr_o), .RtAddr_o(RtAddr_o), .RdAddr_o(RdAddr_o),
    .valid_o(valid_o), .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference state: what EX should hold after each edge.
  logic [5:0]    eCtrl;  // {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst}
  logic [OW-1:0] eAluOp;
  logic [DW-1:0] eRsData, eRtData, eImm;
  logic [AW-1:0] eRsAddr, eRtAddr, eRdAddr;
  logic          eValid;
  int            eCnt;

  task automatic modelReset();
    eCtrl = '0; eAluOp = '0; eRsData = '0; eRtData = '0; eImm = '0;
    eRsAddr = '0; eRtAddr = '0; eRdAddr = '0; eValid = 1'b0; eCnt = 0;
  endtask

  task automatic modelEdge();
    if (rst_i) begin
      modelReset();
      return;
    end
    if (mem_stall_i) return;
    eRsData = RsData_i; eRtData = RtData_i; eImm = Imm_i;
    eRsAddr = RsAddr_i; eRtAddr = RtAddr_i; eRdAddr = RdAddr_i;
    if (stall_i || flush_i) begin
      eCtrl  = '0;
      eAluOp = '0;
      eValid = 1'b0;
      eCnt   = (eCnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : eCnt + 1;
    end else begin
      eCtrl  = {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i};
      eAluOp = ALUOp_i;
      eValid = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string ph);
    chk({ph, ":ctrl"}, DW'({RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o}),
        DW'(eCtrl));
    chk({ph, ":aluop"},  DW'(ALUOp_o),  DW'(eAluOp));
    chk({ph, ":rsdata"}, RsData_o, eRsData);
    chk({ph, ":rtdata"}, RtData_o, eRtData);
    chk({ph, ":imm"},    Imm_o,    eImm);
    chk({ph, ":addrs"},  DW'({RsAddr_o, RtAddr_o, RdAddr_o}), DW'({eRsAddr, eRtAddr, eRdAddr}));
    chk({ph, ":valid"},  DW'(valid_o), DW'(eValid));
    chk({ph, ":cnt"},    DW'(bubble_cnt_o), DW'(eCnt));
  endtask

  task automatic randIn();
    {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i} = 6'($urandom);
    ALUOp_i  = OW'($urandom);
    RsData_i = $urandom; RtData_i = $urandom; Imm_i = $urandom;
    RsAddr_i = AW'($urandom); RtAddr_i = AW'($urandom); RdAddr_i = AW'($urandom);
  endtask

  task automatic cycle(input string ph);
    @(posedge clk_i);
    modelEdge();
    #1;
    checkAll(ph);
  endtask

  // Asserts reset mid-cycle and checks outputs clear without a clock edge.
  task automatic midReset(input string ph);
    #3 rst_i = 1'b1;
    #1;
    modelReset();
    checkAll(ph);
    #1 rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; stall_i = 0; flush_i = 0; mem_stall_i = 0;
    {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i} = '0;
    ALUOp_i = '0; RsData_i = '0; RtData_i = '0; Imm_i = '0;
    RsAddr_i = '0; RtAddr_i = '0; RdAddr_i = '0;
    #2;
    modelReset();
    checkAll("reset");
    @(posedge clk_i); #1 rst_i = 1'b0;

    // Normal capture of a load.
    MemRead_i = 1'b1; RtAddr_i = 5; RsData_i = 32'hDEAD_BEEF;
    cycle("normal");
    chk("normal_memread", DW'(MemRead_o), 1);
    chk("normal_rtaddr",  DW'(RtAddr_o),  5);
    chk("normal_rsdata",  RsData_o, 32'hDEAD_BEEF);
    chk("normal_valid",   DW'(valid_o),   1);

    // Asynchronous reset while a valid instruction sits in EX.
    midReset("async_rst");
    chk("async_rst_valid", DW'(valid_o), 0);
    randIn(); cycle("recapture");

    // Load-use bubble, then normal load.
    randIn(); RegWrite_i = 1'b1; MemRead_i = 1'b1; stall_i = 1'b1;
    cycle("loaduse");
    chk("loaduse_regwrite", DW'(RegWrite_o), 0);
    chk("loaduse_memread",  DW'(MemRead_o),  0);
    chk("loaduse_valid",    DW'(valid_o),    0);
    chk("loaduse_cnt",      DW'(bubble_cnt_o), 1);
    stall_i = 1'b0; randIn(); cycle("after_stall");
    chk("after_stall_valid", DW'(valid_o), 1);

    // Freeze for three cycles with stall pending and changing inputs.
    mem_stall_i = 1'b1; stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randIn(); cycle("freeze");
    end
    mem_stall_i = 1'b0; randIn(); cycle("unfreeze");
    chk("unfreeze_cnt", DW'(bubble_cnt_o), 2);
    stall_i = 1'b0;

    // Simultaneous stall and flush count once.
    stall_i = 1'b1; flush_i = 1'b1; randIn(); cycle("stall_flush");
    chk("stall_flush_cnt", DW'(bubble_cnt_o), 3);
    stall_i = 1'b0; flush_i = 1'b0;

    // Reset in mid-freeze.
    mem_stall_i = 1'b1; randIn(); cycle("prefreeze_rst");
    midReset("freeze_rst");
    mem_stall_i = 1'b0;

    // Saturation.
    stall_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      randIn(); cycle("saturate");
    end
    chk("sat_cnt", DW'(bubble_cnt_o), DW'(4'hF));
    stall_i = 1'b0; randIn(); cycle("post_sat");
    chk("post_sat_cnt", DW'(bubble_cnt_o), DW'(4'hF));

    // Random traffic from a fresh counter.
    midReset("rand_rst");
    for (int i = 0; i < 300; i++) begin
      randIn();
      mem_stall_i = ($urandom_range(0, 3) == 0);
      stall_i     = ($urandom_range(0, 3) == 0);
      flush_i     = ($urandom_range(0, 7) == 0);
      cycle("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
